// File: rtl/addsub_accum_if.sv
// Handshake and result bundle for addsub_accum: request channel, result channel and status.
interface addsub_accum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             carry_borrow;
    logic             insufficient;
    logic             zero;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, op, operand, out_ready,
        input  in_ready, out_valid, acc, carry_borrow, insufficient, zero, op_count
    );

    modport slave (
        input  in_valid, op, operand, out_ready,
        output in_ready, out_valid, acc, carry_borrow, insufficient, zero, op_count
    );
endinterface

// File: rtl/addsub_accum.sv
// Credit accumulator: registered add/sub/load/clear with a single result slot and valid/ready output.
// Optional build macro ADDSUB_ACCUM_SAT_EN makes overflowing ADDs saturate instead of wrap.
module addsub_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    addsub_accum_if.slave bus
);
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cb_q, cb_d;
    logic             ins_q, ins_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic             accept;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign sum          = {1'b0, acc_q} + {1'b0, bus.operand};

    always_comb begin
        acc_d       = acc_q;
        cb_d        = cb_q;
        ins_d       = ins_q;
        cnt_d       = cnt_q;
        out_valid_d = bus.out_ready ? 1'b0 : out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            cb_d        = 1'b0;
            ins_d       = 1'b0;
            cnt_d       = cnt_q + 1'b1;
            case (bus.op)
                OP_ADD: begin
                    cb_d = sum[WIDTH];
`ifdef ADDSUB_ACCUM_SAT_EN
                    acc_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                    acc_d = sum[WIDTH-1:0];
`endif
                end
                OP_SUB: begin
                    // A refused SUB still produces a result, but never commits.
                    if (bus.operand > acc_q) begin
                        cb_d  = 1'b1;
                        ins_d = 1'b1;
                        cnt_d = cnt_q;
                    end else begin
                        acc_d = acc_q - bus.operand;
                    end
                end
                OP_LOAD:  acc_d = bus.operand;
                OP_CLEAR: acc_d = '0;
                default:  acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cb_q        <= 1'b0;
            ins_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            cb_q        <= cb_d;
            ins_q       <= ins_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.acc          = acc_q;
    assign bus.carry_borrow = cb_q;
    assign bus.insufficient = ins_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.op_count     = cnt_q;
    assign bus.zero         = (acc_q == '0);
endmodule

// File: tb/tb_addsub_accum.sv
// Scoreboard bench for addsub_accum at WIDTH=5: directed scenarios, back-pressure, reset under stall, random ops.
module tb_addsub_accum;
    localparam int W = 5;
    localparam int C = 8;

    typedef struct {
        logic [W-1:0] acc;
        logic         cb;
        logic         ins;
        logic [C-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    addsub_accum_if #(.WIDTH(W), .CNT_W(C)) bus ();
    addsub_accum #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] m_acc;
    logic [C-1:0] m_cnt;
    logic         m_cb, m_ins;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_push(input logic [1:0] o, input logic [W-1:0] d);
        logic [W:0] s;
        exp_t e;
        m_cb  = 1'b0;
        m_ins = 1'b0;
        case (o)
            2'b00: begin
                s     = {1'b0, m_acc} + {1'b0, d};
                m_cb  = s[W];
`ifdef ADDSUB_ACCUM_SAT_EN
                m_acc = s[W] ? {W{1'b1}} : s[W-1:0];
`else
                m_acc = s[W-1:0];
`endif
                m_cnt++;
            end
            2'b01: begin
                if (d > m_acc) begin
                    m_cb  = 1'b1;
                    m_ins = 1'b1;
                end else begin
                    m_acc = m_acc - d;
                    m_cnt++;
                end
            end
            2'b10: begin m_acc = d;  m_cnt++; end
            default: begin m_acc = '0; m_cnt++; end
        endcase
        e.acc = m_acc; e.cb = m_cb; e.ins = m_ins; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] d);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.operand  = d;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        else model_push(o, d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Each result is scored at the edge where it is consumed.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_acc", 32'(bus.acc), 32'(e.acc));
                chk("sb_cb", 32'(bus.carry_borrow), 32'(e.cb));
                chk("sb_ins", 32'(bus.insufficient), 32'(e.ins));
                chk("sb_cnt", 32'(bus.op_count), 32'(e.cnt));
                chk("sb_zero", 32'(bus.zero), 32'(e.acc == '0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hold;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.op = 2'b00; bus.operand = '0; bus.out_ready = 1'b1;
        m_acc = '0; m_cnt = '0; m_cb = 1'b0; m_ins = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_acc", 32'(bus.acc), 0);
        chk("rst_cb", 32'(bus.carry_borrow), 0);
        chk("rst_ins", 32'(bus.insufficient), 0);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_cnt", 32'(bus.op_count), 0);
        chk("rst_zero", 32'(bus.zero), 1);
        chk("rst_rdy", 32'(bus.in_ready), 1);
        @(posedge clk); #1;

        issue(2'b10, 5'd10);
        chk("load_ov", 32'(bus.out_valid), 1);
        issue(2'b00, 5'd5);
        @(negedge clk);
        chk("add_acc", 32'(bus.acc), 15);
        chk("add_cb", 32'(bus.carry_borrow), 0);
        chk("add_cnt", 32'(bus.op_count), 2);
        chk("add_ov", 32'(bus.out_valid), 1);
        @(posedge clk); #1;

        issue(2'b01, 5'd5);
        issue(2'b01, 5'd12);
        @(negedge clk);
        chk("subref_acc", 32'(bus.acc), 10);
        chk("subref_cb", 32'(bus.carry_borrow), 1);
        chk("subref_ins", 32'(bus.insufficient), 1);
        chk("subref_cnt", 32'(bus.op_count), 3);
        @(posedge clk); #1;

        issue(2'b01, 5'd10);
        @(negedge clk);
        chk("sub0_acc", 32'(bus.acc), 0);
        chk("sub0_zero", 32'(bus.zero), 1);
        chk("sub0_cb", 32'(bus.carry_borrow), 0);
        chk("sub0_ins", 32'(bus.insufficient), 0);
        @(posedge clk); #1;
        issue(2'b11, 5'd9);
        @(negedge clk);
        chk("clr_acc", 32'(bus.acc), 0);
        chk("clr_cnt", 32'(bus.op_count), 5);
        @(posedge clk); #1;

        issue(2'b10, 5'd30);
        issue(2'b00, 5'd5);
        @(negedge clk);
`ifdef ADDSUB_ACCUM_SAT_EN
        chk("ovf_acc", 32'(bus.acc), 31);
`else
        chk("ovf_acc", 32'(bus.acc), 3);
`endif
        chk("ovf_cb", 32'(bus.carry_borrow), 1);
        @(posedge clk); #1;

        // Back-pressure: ADD 1 result held, ADD 7 waits on in_ready.
        issue(2'b00, 5'd1);
        bus.out_ready = 1'b0;
        hold = m_acc;
        bus.in_valid = 1'b1; bus.op = 2'b00; bus.operand = 5'd7;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy", 32'(bus.in_ready), 0);
            chk("bp_acc", 32'(bus.acc), 32'(hold));
            chk("bp_ov", 32'(bus.out_valid), 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 32'(bus.in_ready), 1);
        model_push(2'b00, 5'd7);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_acc7", 32'(bus.acc), 32'(m_acc));
        @(posedge clk); #1;

        // Random back-to-back traffic, long enough to wrap op_count.
        for (int i = 0; i < 300; i++)
            issue(2'($urandom_range(0, 3)), W'($urandom_range(0, 31)));
        @(negedge clk);
        chk("rand_cnt", 32'(bus.op_count), 32'(m_cnt));
        @(posedge clk); #1;

        // Reset with a result pending under stall.
        issue(2'b10, 5'd19);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_ov", 32'(bus.out_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.op = 2'b00; bus.operand = 5'd4;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        sb.delete();
        m_acc = '0; m_cnt = '0;
        @(negedge clk);
        chk("srst_ov", 32'(bus.out_valid), 0);
        chk("srst_acc", 32'(bus.acc), 0);
        chk("srst_cnt", 32'(bus.op_count), 0);
        chk("srst_rdy", 32'(bus.in_ready), 1);
        chk("srst_zero", 32'(bus.zero), 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        issue(2'b00, 5'd6);
        @(negedge clk);
        chk("post_rst_acc", 32'(bus.acc), 6);
        chk("post_rst_cnt", 32'(bus.op_count), 1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
